// File: rtl/cf_stream_ctrl_pkg.sv
// Shared canonical-form definitions: the stream-controller FSM state
// encoding and a bit-reversal helper used for the constant sequence.
package cf_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cf_state_t;

    localparam int unsigned REV_MAX_W = 32;

    // Reverses the low w bits of v (w <= REV_MAX_W); upper bits come back zero.
    // Reversing the full word and shifting down avoids variable bit indices.
    function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] v,
                                                     input int unsigned         w);
        logic [REV_MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (REV_MAX_W - w);
    endfunction

endpackage

// File: rtl/cf_stream_ctrl_const_gen.sv
// Constant-select generator for the canonical-form datapath.
// A free-running-on-advance counter, wrapping modulo 2**NUM_CONSTS, whose
// output is optionally bit-reversed.
//   clk     : clock
//   rst     : synchronous active-high reset (counter to zero)
//   clear   : synchronous clear (start of a run)
//   advance : step the counter by one
//   bitrev  : 1 = present the bit-reversed count
//   value   : constant-select output
module cf_const_gen
    import cf_stream_ctrl_pkg::*;
#(
    parameter int NUM_CONSTS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic                  bitrev,
    output logic [NUM_CONSTS-1:0] value
);

    logic [NUM_CONSTS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + NUM_CONSTS'(1);
        end
    end

    assign value = bitrev ? NUM_CONSTS'(bit_rev(REV_MAX_W'(cnt), NUM_CONSTS)) : cnt;

endmodule

// File: rtl/cf_stream_ctrl.sv
// Stream controller for a canonical-form bitstream datapath.
// Sequences the constant-select bus over a run of len samples, forwards the
// variable bits, and counts ones on every datapath output bitstream.
//   clk, rst          : clock, synchronous active-high reset
//   start, len, bitrev: run request with sample count and constant order
//   in_valid/in_ready : upstream sample handshake; in_vars sample bits
//   cf_const, cf_vars : drive to the datapath; cf_outputs its result bits
//   busy, done        : RUN / DONE status
//   counts            : per-output ones count, output k at [k*LEN_W +: LEN_W]
//   ack               : consumer releases the results in DONE
module cf_stream_ctrl
    import cf_stream_ctrl_pkg::*;
#(
    parameter int NUM_CONSTS  = 3,
    parameter int NUM_VARS    = 2,
    parameter int NUM_OUTPUTS = 2,
    parameter int LEN_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN_W-1:0]             len,
    input  logic                         bitrev,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_VARS-1:0]          in_vars,
    output logic [NUM_CONSTS-1:0]        cf_const,
    output logic [NUM_VARS-1:0]          cf_vars,
    input  logic [NUM_OUTPUTS-1:0]       cf_outputs,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_OUTPUTS*LEN_W-1:0] counts,
    input  logic                         ack
);

    cf_state_t        state;
    cf_state_t        state_next;
    logic [LEN_W-1:0] len_q;
    logic             bitrev_q;
    logic [LEN_W-1:0] sample_cnt;
    logic [LEN_W-1:0] counts_q [NUM_OUTPUTS];

    logic start_ok;
    logic accept;
    logic last;

    assign start_ok = (state == ST_IDLE) && start;
    assign accept   = in_valid && in_ready;
    // len_q is non-zero whenever RUN is reached, so len_q-1 never wraps here.
    assign last     = accept && (sample_cnt == len_q - LEN_W'(1));

    assign cf_vars = in_vars;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run bookkeeping and ones counters; counts hold through DONE and IDLE
    // until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            bitrev_q   <= 1'b0;
            sample_cnt <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                counts_q[k] <= '0;
            end
        end else if (start_ok) begin
            len_q      <= len;
            bitrev_q   <= bitrev;
            sample_cnt <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                counts_q[k] <= '0;
            end
        end else if (accept) begin
            sample_cnt <= sample_cnt + LEN_W'(1);
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                counts_q[k] <= counts_q[k] + LEN_W'(cf_outputs[k]);
            end
        end
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_counts
        assign counts[k*LEN_W +: LEN_W] = counts_q[k];
    end

    cf_const_gen #(
        .NUM_CONSTS(NUM_CONSTS)
    ) u_const_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_ok),
        .advance(accept),
        .bitrev (bitrev_q),
        .value  (cf_const)
    );

endmodule

// File: tb/tb_cf_stream_ctrl.sv
// Testbench for cf_stream_ctrl with default parameters (3 consts, 2 vars,
// 2 outputs, 8-bit lengths). Inputs change after the falling edge and
// outputs are compared just before the next rising edge.
module tb_cf_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        bitrev;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_vars;
    logic [2:0]  cf_const;
    logic [1:0]  cf_vars;
    logic [1:0]  cf_outputs;
    logic        busy;
    logic        done;
    logic [15:0] counts;
    logic        ack;

    int n_tests;
    int n_fail;

    cf_stream_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bitrev    (bitrev),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vars   (in_vars),
        .cf_const  (cf_const),
        .cf_vars   (cf_vars),
        .cf_outputs(cf_outputs),
        .busy      (busy),
        .done      (done),
        .counts    (counts),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       br;
        logic       v;
        logic       ack;
        logic [1:0] vars;
        logic [1:0] outs;
        logic       e_busy;
        logic       e_done;
        logic       e_rdy;
        logic [2:0] e_const;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic s, input logic [7:0] l, input logic b,
                                input logic v, input logic a, input logic [1:0] vr,
                                input logic [1:0] o, input logic eb, input logic ed,
                                input logic er, input logic [2:0] ec,
                                input logic [7:0] e0, input logic [7:0] e1);
        vec_t t;
        t.start = s;  t.len = l;   t.br = b;     t.v = v;     t.ack = a;
        t.vars = vr;  t.outs = o;  t.e_busy = eb; t.e_done = ed; t.e_rdy = er;
        t.e_const = ec; t.e_c0 = e0; t.e_c1 = e1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts seen before each edge of the binary run (outs = const[1:0]).
    logic [7:0] c0e  [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    logic [7:0] c1e  [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
    logic [2:0] rev_e[8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // IDLE, then an 8-sample binary run with stray start/ack, DONE, ack.
        tbl[0]  = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        tbl[1]  = mk(1'b1, 8'd8, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tbl[2+i] = mk(1'(i == 3), 8'd2, 1'b1, 1'b1, 1'(i == 5), ~i[1:0], i[1:0],
                          1'b1, 1'b0, 1'b1, i[2:0], c0e[i], c1e[i]);
        end
        tbl[10] = mk(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 3'd0, 8'd4, 8'd4);
        tbl[11] = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd4, 8'd4);
        // Back in IDLE with counts held; start an 8-sample bit-reversed run.
        tbl[12] = mk(1'b1, 8'd8, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 8'd4, 8'd4);
        for (int j = 0; j < 8; j++) begin
            tbl[13+j] = mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, j[1:0], 2'b11,
                           1'b1, 1'b0, 1'b1, rev_e[j], 8'(j), 8'(j));
        end
        tbl[21] = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd8, 8'd8);
        tbl[22] = mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 8'd8, 8'd8);

        rst = 1'b1; start = 1'b0; len = 8'd0; bitrev = 1'b0; in_valid = 1'b0;
        in_vars = 2'b00; cf_outputs = 2'b00; ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busy",     32'(busy),     32'd0);
        chk("reset done",     32'(done),     32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset counts",   32'(counts),   32'd0);
        chk("reset cf_const", 32'(cf_const), 32'd0);

        for (int r = 0; r < 23; r++) begin
            @(negedge clk);
            start = tbl[r].start; len = tbl[r].len; bitrev = tbl[r].br;
            in_valid = tbl[r].v; ack = tbl[r].ack; in_vars = tbl[r].vars;
            cf_outputs = tbl[r].outs;
            #1;
            chk($sformatf("row%0d busy", r),     32'(busy),          32'(tbl[r].e_busy));
            chk($sformatf("row%0d done", r),     32'(done),          32'(tbl[r].e_done));
            chk($sformatf("row%0d in_ready", r), 32'(in_ready),      32'(tbl[r].e_rdy));
            chk($sformatf("row%0d cf_const", r), 32'(cf_const),      32'(tbl[r].e_const));
            chk($sformatf("row%0d cf_vars", r),  32'(cf_vars),       32'(tbl[r].vars));
            chk($sformatf("row%0d count0", r),   32'(counts[7:0]),   32'(tbl[r].e_c0));
            chk($sformatf("row%0d count1", r),   32'(counts[15:8]),  32'(tbl[r].e_c1));
        end

        // len=5, outputs tied 01, in_valid toggling: counts {0,5}.
        @(negedge clk);
        start = 1'b1; len = 8'd5; bitrev = 1'b0; in_valid = 1'b0; ack = 1'b0;
        cf_outputs = 2'b01;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0);
            #1;
            if (c < 9) begin
                chk($sformatf("toggle c%0d busy", c),     32'(busy),     32'd1);
                chk($sformatf("toggle c%0d cf_const", c), 32'(cf_const), 32'((c + 1) / 2));
            end else begin
                chk("toggle done", 32'(done), 32'd1);
                chk("toggle busy", 32'(busy), 32'd0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("toggle counts", 32'(counts), 32'h0000_0005);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("toggle ack done", 32'(done), 32'd0);
        chk("toggle ack busy", 32'(busy), 32'd0);

        // len=0: straight to DONE with cleared counts, then ack to IDLE.
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("len0 done",   32'(done),   32'd1);
        chk("len0 busy",   32'(busy),   32'd0);
        chk("len0 counts", 32'(counts), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("len0 ack done", 32'(done), 32'd0);

        // rst on the third accepted sample of a len=8 run.
        @(negedge clk);
        start = 1'b1; len = 8'd8; bitrev = 1'b0; in_valid = 1'b1; cf_outputs = 2'b11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort pre counts", 32'(counts),   32'h0000_0202);
        chk("abort pre const",  32'(cf_const), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort busy",     32'(busy),     32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd0);
        chk("abort done",     32'(done),     32'd0);
        chk("abort counts",   32'(counts),   32'd0);
        chk("abort cf_const", 32'(cf_const), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort c%0d no done", c), 32'(done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
